// File: rtl/lane_stream_pkg.sv
// Shared types and helpers for the lane stream serializer.
package lane_stream_pkg;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  localparam int DATA_TYPE_RAW  = 0;
  localparam int DATA_TYPE_PROD = 1;

  // Number of output words produced per captured vector.
  function automatic int n_out(input int n_lanes, input int data_type);
    return (data_type == DATA_TYPE_PROD) ? (n_lanes + 1) / 2 : n_lanes;
  endfunction
endpackage

// File: rtl/lane_mul.sv
// Combinational signed multiplier, full-width product.
module lane_mul #(
  parameter int NB_DATA = 8
) (
  input  logic signed [NB_DATA-1:0]   a_i,
  input  logic signed [NB_DATA-1:0]   b_i,
  output logic signed [2*NB_DATA-1:0] p_o
);
  assign p_o = a_i * b_i;
endmodule

// File: rtl/lane_stream_serializer.sv
// Captures a packed lane vector and streams it out one word per beat,
// either as sign-extended lanes or as pairwise signed products.
module lane_stream_serializer
  import lane_stream_pkg::*;
#(
  parameter int NB_DATA   = 8,
  parameter int N_LANES   = 8,
  parameter int DATA_TYPE = 0,
  parameter int NB_CNT    = 4
) (
  input  logic                       clock,
  input  logic                       i_reset_n,
  input  logic [N_LANES*NB_DATA-1:0] i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [2*NB_DATA-1:0]       o_data,
  output logic                       o_valid,
  output logic                       o_last,
  input  logic                       i_ready
);
  localparam int                N_OUT    = n_out(N_LANES, DATA_TYPE);
  localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(N_OUT - 1);

  state_e                      state_q, state_d;
  logic [NB_CNT-1:0]           cnt_q, cnt_d;
  logic [2*NB_DATA-1:0]        data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        last_q, last_d;
  logic signed [NB_DATA-1:0]   lanes_q [N_LANES-1:0];
  logic signed [NB_DATA-1:0]   lanes_d [N_LANES-1:0];
  logic signed [NB_DATA-1:0]   in_lane [N_LANES-1:0];
  logic signed [NB_DATA-1:0]   src     [N_LANES-1:0];
  logic                        accept;
  logic [NB_CNT-1:0]           idx;
  logic signed [2*NB_DATA-1:0] word;

  for (genvar k = 0; k < N_LANES; k++) begin : g_slice
    assign in_lane[k] = i_data[(k+1)*NB_DATA-1 -: NB_DATA];
  end

  assign o_ready = (state_q == IDLE) || ((state_q == SEND) && last_q && i_ready);
  assign accept  = i_valid && o_ready;

  // The word formed this cycle is either word 0 of the incoming vector or the
  // next word of the held vector; one datapath serves both.
  assign idx = accept ? '0 : cnt_q + 1'b1;

  always_comb begin
    for (int k = 0; k < N_LANES; k++) src[k] = accept ? in_lane[k] : lanes_q[k];
  end

  if (DATA_TYPE == DATA_TYPE_RAW) begin : g_raw
    logic signed [NB_DATA-1:0] raw;
    always_comb begin
      raw = '0;
      for (int k = 0; k < N_LANES; k++) if (idx == NB_CNT'(k)) raw = src[k];
    end
    assign word = {{NB_DATA{raw[NB_DATA-1]}}, raw};
  end else begin : g_prod
    logic signed [NB_DATA-1:0]   pa [N_OUT-1:0];
    logic signed [NB_DATA-1:0]   pb [N_OUT-1:0];
    logic [N_OUT-1:0]            tail;
    logic signed [NB_DATA-1:0]   op_a, op_b;
    logic                        is_tail;
    logic signed [2*NB_DATA-1:0] prod;

    // An odd lane count leaves an unpaired final lane, passed through sign-extended.
    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
      assign pa[j] = src[2*j];
      if (2*j + 1 < N_LANES) begin : g_full
        assign pb[j]   = src[2*j+1];
        assign tail[j] = 1'b0;
      end else begin : g_odd
        assign pb[j]   = '0;
        assign tail[j] = 1'b1;
      end
    end

    always_comb begin
      op_a    = '0;
      op_b    = '0;
      is_tail = 1'b0;
      for (int j = 0; j < N_OUT; j++) begin
        if (idx == NB_CNT'(j)) begin
          op_a    = pa[j];
          op_b    = pb[j];
          is_tail = tail[j];
        end
      end
    end

    lane_mul #(.NB_DATA(NB_DATA)) u_mul (.a_i(op_a), .b_i(op_b), .p_o(prod));

    assign word = is_tail ? {{NB_DATA{op_a[NB_DATA-1]}}, op_a} : prod;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    for (int k = 0; k < N_LANES; k++) lanes_d[k] = lanes_q[k];
    if (accept) begin
      for (int k = 0; k < N_LANES; k++) lanes_d[k] = in_lane[k];
      state_d = SEND;
      cnt_d   = '0;
      data_d  = word;
      valid_d = 1'b1;
      last_d  = (LAST_CNT == '0);
    end else begin
      case (state_q)
        SEND: begin
          if (i_ready) begin
            if (last_q) begin
              state_d = IDLE;
              valid_d = 1'b0;
              last_d  = 1'b0;
            end else begin
              cnt_d  = idx;
              data_d = word;
              last_d = (idx == LAST_CNT);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      for (int k = 0; k < N_LANES; k++) lanes_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      for (int k = 0; k < N_LANES; k++) lanes_q[k] <= lanes_d[k];
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;
endmodule

// File: tb/tb_lane_stream_serializer.sv
// Directed bench: raw 8-lane instance and product-mode 5-lane instance.
module tb_lane_stream_serializer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] data0;
  logic        valid0, rdy0, ordy0, ovld0, olast0;
  logic [15:0] odata0;
  logic [39:0] data1;
  logic        valid1, rdy1, ordy1, ovld1, olast1;
  logic [15:0] odata1;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lane_stream_serializer #(.NB_DATA(8), .N_LANES(8), .DATA_TYPE(0), .NB_CNT(4)) u0 (
    .clock(clk), .i_reset_n(rst_n), .i_data(data0), .i_valid(valid0), .o_ready(ordy0),
    .o_data(odata0), .o_valid(ovld0), .o_last(olast0), .i_ready(rdy0));

  lane_stream_serializer #(.NB_DATA(8), .N_LANES(5), .DATA_TYPE(1), .NB_CNT(4)) u1 (
    .clock(clk), .i_reset_n(rst_n), .i_data(data1), .i_valid(valid1), .o_ready(ordy1),
    .o_data(odata1), .o_valid(ovld1), .o_last(olast1), .i_ready(rdy1));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] vec8(input int base);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = 8'(base + k);
    return v;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; valid0 = 1'b0; valid1 = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
    data0 = '0; data1 = '0;
    step; step;
    n_cmp++; if (ovld0 !== 1'b0) begin n_err++; $display("FAIL reset_valid0: got %b want 0", ovld0); end
    n_cmp++; if (olast0 !== 1'b0) begin n_err++; $display("FAIL reset_last0: got %b want 0", olast0); end
    n_cmp++; if (odata0 !== 16'h0000) begin n_err++; $display("FAIL reset_data0: got %h want 0000", odata0); end
    n_cmp++; if (ordy0 !== 1'b1) begin n_err++; $display("FAIL reset_ready0: got %b want 1", ordy0); end
    n_cmp++; if (ovld1 !== 1'b0) begin n_err++; $display("FAIL reset_valid1: got %b want 0", ovld1); end
    n_cmp++; if (ordy1 !== 1'b1) begin n_err++; $display("FAIL reset_ready1: got %b want 1", ordy1); end
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_raw_stream;
    data0 = vec8(1); valid0 = 1'b1;
    #1;
    n_cmp++; if (ordy0 !== 1'b1) begin n_err++; $display("FAIL raw_idle_ready: got %b want 1", ordy0); end
    step;
    valid0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (ovld0 !== 1'b1) begin n_err++; $display("FAIL raw_valid%0d: got %b want 1", k, ovld0); end
      n_cmp++; if (odata0 !== 16'(k + 1)) begin n_err++; $display("FAIL raw_word%0d: got %h want %h", k, odata0, 16'(k + 1)); end
      n_cmp++; if (olast0 !== (k == 7)) begin n_err++; $display("FAIL raw_last%0d: got %b want %b", k, olast0, (k == 7)); end
      step;
    end
    n_cmp++; if (ovld0 !== 1'b0) begin n_err++; $display("FAIL raw_end_valid: got %b want 0", ovld0); end
  endtask

  task automatic test_sign_ext;
    data0 = 64'h0000_0000_0000_80FF; valid0 = 1'b1;
    step;
    valid0 = 1'b0;
    n_cmp++; if (odata0 !== 16'hFFFF) begin n_err++; $display("FAIL sext_w0: got %h want FFFF", odata0); end
    step;
    n_cmp++; if (odata0 !== 16'hFF80) begin n_err++; $display("FAIL sext_w1: got %h want FF80", odata0); end
    repeat (7) step;
    n_cmp++; if (ovld0 !== 1'b0) begin n_err++; $display("FAIL sext_end_valid: got %b want 0", ovld0); end
  endtask

  task automatic test_prod;
    data1 = 40'h07_05_FC_03_02; valid1 = 1'b1;
    step;
    valid1 = 1'b0;
    n_cmp++; if (odata1 !== 16'h0006 || olast1 !== 1'b0) begin n_err++; $display("FAIL prod_w0: got %h/%b want 0006/0", odata1, olast1); end
    step;
    n_cmp++; if (odata1 !== 16'hFFEC || olast1 !== 1'b0) begin n_err++; $display("FAIL prod_w1: got %h/%b want FFEC/0", odata1, olast1); end
    step;
    n_cmp++; if (odata1 !== 16'h0007 || olast1 !== 1'b1) begin n_err++; $display("FAIL prod_tail: got %h/%b want 0007/1", odata1, olast1); end
    step;
    n_cmp++; if (ovld1 !== 1'b0) begin n_err++; $display("FAIL prod_end_valid: got %b want 0", ovld1); end
    data1 = 40'h00_00_00_80_80; valid1 = 1'b1;
    step;
    valid1 = 1'b0;
    n_cmp++; if (odata1 !== 16'h4000) begin n_err++; $display("FAIL prod_minmin: got %h want 4000", odata1); end
    step; step;
    n_cmp++; if (odata1 !== 16'h0000 || olast1 !== 1'b1) begin n_err++; $display("FAIL prod_zero_tail: got %h/%b want 0000/1", odata1, olast1); end
    step;
  endtask

  task automatic test_backpressure;
    data0 = vec8(1); valid0 = 1'b1;
    step;
    valid0 = 1'b0;
    step; step;
    rdy0 = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (odata0 !== 16'h0003 || olast0 !== 1'b0 || ovld0 !== 1'b1) begin n_err++; $display("FAIL bp_hold%0d: got %h/%b/%b want 0003/0/1", c, odata0, olast0, ovld0); end
      n_cmp++; if (ordy0 !== 1'b0) begin n_err++; $display("FAIL bp_ready%0d: got %b want 0", c, ordy0); end
      step;
    end
    rdy0 = 1'b1;
    for (int k = 2; k < 8; k++) begin
      n_cmp++; if (odata0 !== 16'(k + 1) || olast0 !== (k == 7)) begin n_err++; $display("FAIL bp_word%0d: got %h/%b want %h/%b", k, odata0, olast0, 16'(k + 1), (k == 7)); end
      step;
    end
    n_cmp++; if (ovld0 !== 1'b0) begin n_err++; $display("FAIL bp_end_valid: got %b want 0", ovld0); end
  endtask

  task automatic test_back_to_back;
    data0 = vec8(1); valid0 = 1'b1;
    step;
    valid0 = 1'b0;
    repeat (7) step;
    n_cmp++; if (odata0 !== 16'h0008 || olast0 !== 1'b1) begin n_err++; $display("FAIL b2b_a_last: got %h/%b want 0008/1", odata0, olast0); end
    data0 = vec8(16); valid0 = 1'b1; rdy0 = 1'b0;
    #1;
    n_cmp++; if (ordy0 !== 1'b0) begin n_err++; $display("FAIL b2b_stall_ready: got %b want 0", ordy0); end
    step;
    n_cmp++; if (odata0 !== 16'h0008 || olast0 !== 1'b1) begin n_err++; $display("FAIL b2b_stall_hold: got %h/%b want 0008/1", odata0, olast0); end
    rdy0 = 1'b1;
    #1;
    n_cmp++; if (ordy0 !== 1'b1) begin n_err++; $display("FAIL b2b_handoff_ready: got %b want 1", ordy0); end
    step;
    valid0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (ovld0 !== 1'b1 || odata0 !== 16'(16 + k) || olast0 !== (k == 7)) begin n_err++; $display("FAIL b2b_b_word%0d: got %b/%h/%b want 1/%h/%b", k, ovld0, odata0, olast0, 16'(16 + k), (k == 7)); end
      step;
    end
    n_cmp++; if (ovld0 !== 1'b0) begin n_err++; $display("FAIL b2b_end_valid: got %b want 0", ovld0); end
  endtask

  task automatic test_reset_mid;
    data0 = vec8(1); valid0 = 1'b1;
    step;
    valid0 = 1'b0;
    step; step; step;
    n_cmp++; if (odata0 !== 16'h0004) begin n_err++; $display("FAIL rmid_beat3: got %h want 0004", odata0); end
    rst_n = 1'b0;
    step;
    n_cmp++; if (ovld0 !== 1'b0 || olast0 !== 1'b0 || odata0 !== 16'h0000) begin n_err++; $display("FAIL rmid_cleared: got %b/%b/%h want 0/0/0000", ovld0, olast0, odata0); end
    n_cmp++; if (ordy0 !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %b want 1", ordy0); end
    rst_n = 1'b1;
    data0 = vec8(33); valid0 = 1'b1;
    step;
    valid0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (odata0 !== 16'(33 + k) || olast0 !== (k == 7)) begin n_err++; $display("FAIL rmid_word%0d: got %h/%b want %h/%b", k, odata0, olast0, 16'(33 + k), (k == 7)); end
      step;
    end
    n_cmp++; if (ovld0 !== 1'b0) begin n_err++; $display("FAIL rmid_end_valid: got %b want 0", ovld0); end
  endtask

  initial begin
    test_reset;
    test_raw_stream;
    test_sign_ext;
    test_prod;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
